// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request/response bus between core and data memory
//   req_valid  core -> mem  request present
//   req_ready  mem -> core  responder can accept
//   req_write  core -> mem  1 = store, 0 = load
//   req_size   core -> mem  00 byte, 01 half, 10 word, 11 illegal
//   req_signed core -> mem  sign-extend loads
//   req_addr   core -> mem  byte address
//   req_wdata  core -> mem  right-aligned store data
//   rsp_valid  mem -> core  one-cycle response strobe
//   rsp_rdata  mem -> core  load result
//   rsp_error  mem -> core  request rejected
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word RAM responder for byte/half/word loads and stores
//   clk    rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    slave side of data_mem_responder_if (request in, response out)
module data_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input logic                 clk,
    input logic                 reset,
    data_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        q_write, q_signed;
    logic [1:0]  q_size;
    logic [31:0] q_addr, q_wdata;
    logic [31:0] mem [2**ADDR_W];

    logic              accept, enter_resp, err;
    logic              c_write, c_signed;
    logic [1:0]        c_size, lane;
    logic [31:0]       c_addr, c_wdata, rd_word, ld_data, wr_data;
    logic [3:0]        be;
    logic [ADDR_W-1:0] idx;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;

    assign bus.req_ready = (state == IDLE) && !reset;
    assign accept        = bus.req_valid && bus.req_ready;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: if (accept) begin
                cnt_next   = 4'(LATENCY - 1);
                state_next = (LATENCY > 1) ? WAIT : RESP;
            end
            WAIT: begin
                cnt_next   = cnt - 4'd1;
                state_next = (cnt == 4'd1) ? RESP : WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign enter_resp = (state_next == RESP);

    // With LATENCY==1 the access happens on the accept edge itself, so the
    // live request fields are used while still in IDLE.
    assign c_write  = (state == IDLE) ? bus.req_write  : q_write;
    assign c_size   = (state == IDLE) ? bus.req_size   : q_size;
    assign c_signed = (state == IDLE) ? bus.req_signed : q_signed;
    assign c_addr   = (state == IDLE) ? bus.req_addr   : q_addr;
    assign c_wdata  = (state == IDLE) ? bus.req_wdata  : q_wdata;

    assign err = (c_size == 2'b11)
              || (c_size == 2'b01 && c_addr[0])
              || (c_size == 2'b10 && |c_addr[1:0])
              || ((c_addr >> (ADDR_W + 2)) != 32'd0);

    assign idx  = c_addr[ADDR_W+1:2];
    assign lane = c_addr[1:0];

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = rd_word;
        wr_data = c_wdata;
        be      = 4'b1111;
        if (c_size == 2'b00) begin
            ld_data = {{24{c_signed & rd_byte[7]}}, rd_byte};
            wr_data = {4{c_wdata[7:0]}};
            be      = 4'b0001 << lane;
        end else if (c_size == 2'b01) begin
            ld_data = {{16{c_signed & rd_half[15]}}, rd_half};
            wr_data = {2{c_wdata[15:0]}};
            be      = lane[1] ? 4'b1100 : 4'b0011;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            q_write       <= 1'b0;
            q_size        <= 2'b00;
            q_signed      <= 1'b0;
            q_addr        <= 32'd0;
            q_wdata       <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            bus.rsp_error <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            bus.rsp_valid <= enter_resp;
            if (accept) begin
                q_write  <= bus.req_write;
                q_size   <= bus.req_size;
                q_signed <= bus.req_signed;
                q_addr   <= bus.req_addr;
                q_wdata  <= bus.req_wdata;
            end
            if (enter_resp) begin
                bus.rsp_rdata <= (c_write || err) ? 32'd0 : ld_data;
                bus.rsp_error <= err;
            end
        end
    end

    // RAM contents survive reset; only the committing edge writes.
    always_ff @(posedge clk) begin
        if (enter_resp && c_write && !err && !reset) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: scoreboard bench for data_mem_responder (ADDR_W=10, LATENCY=2)
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    data_mem_responder_if bus();

    data_mem_responder #(.ADDR_W(10), .LATENCY(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int asserts = 0;
    int fails = 0;
    int cyc = 0;
    logic [32:0] sb_q[$];
    int acc_q[$];
    logic [32:0] e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Edge counter and accept log (edge index of each accept).
    always @(posedge clk) begin
        if (reset) acc_q.delete();
        else if (bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
        cyc++;
    end

    // Monitor: every response strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid) begin
            if (sb_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("rdata", bus.rsp_rdata, e[31:0]);
                chk("error", {31'd0, bus.rsp_error}, {31'd0, e[32]});
                if (acc_q.size() == 0) chk("no_accept", 32'd1, 32'd0);
                else chk("latency", cyc - acc_q.pop_front(), 32'd2);
            end
        end
    end

    task automatic send(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        bit ok = 0;
        bus.req_write = w; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = ~wd; bus.req_size = 2'b11; bus.req_write = ~w;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("rsp_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        sb_q.push_back({exp_err, exp_rd});
        send(w, sz, sg, a, wd);
        drain();
    endtask

    initial begin
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0;
        bus.req_signed = 0; bus.req_addr = 0; bus.req_wdata = 0;
        repeat (2) @(negedge clk);
        chk("reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_error", {31'd0, bus.rsp_error}, 32'd0);
        chk("reset_ready", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.req_ready}, 32'd1);

        // word store/load
        issue(1, 2'b10, 0, 32'h10, 32'h1234_5678, 32'h0, 0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234_5678, 0);
        // byte lanes
        issue(1, 2'b00, 0, 32'h11, 32'h0000_00FF, 32'h0, 0);
        issue(0, 2'b00, 1, 32'h11, 32'h0, 32'hFFFF_FFFF, 0);
        issue(0, 2'b00, 0, 32'h11, 32'h0, 32'h0000_00FF, 0);
        issue(0, 2'b00, 1, 32'h10, 32'h0, 32'h0000_0078, 0);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h1234_FF78, 0);
        // upper half
        issue(1, 2'b01, 0, 32'h12, 32'h0000_8001, 32'h0, 0);
        issue(0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF_8001, 0);
        issue(0, 2'b01, 0, 32'h12, 32'h0, 32'h0000_8001, 0);
        issue(0, 2'b10, 1, 32'h10, 32'h0, 32'h8001_FF78, 0);
        // errors
        issue(0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 1);
        issue(1, 2'b10, 0, 32'h12, 32'hAAAA_AAAA, 32'h0, 1);
        issue(0, 2'b01, 1, 32'h13, 32'h0, 32'h0, 1);
        issue(1, 2'b11, 0, 32'h10, 32'h5555_5555, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h1000, 32'h0, 32'h0, 1);
        issue(1, 2'b10, 0, 32'h1010, 32'hBAD0_BAD0, 32'h0, 1);
        issue(0, 2'b10, 0, 32'h10, 32'h0, 32'h8001_FF78, 0);
        // top word of the array is in range
        issue(1, 2'b10, 0, 32'hFFC, 32'hA5A5_5A5A, 32'h0, 0);
        issue(0, 2'b10, 0, 32'hFFC, 32'h0, 32'hA5A5_5A5A, 0);

        // back-to-back: valid held for 10 cycles accepts every third edge
        bus.req_write = 0; bus.req_size = 2'b10; bus.req_signed = 0;
        bus.req_addr = 32'h10; bus.req_wdata = 0; bus.req_valid = 1;
        repeat (4) sb_q.push_back({1'b0, 32'h8001_FF78});
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("held_ready_%0d", k), {31'd0, bus.req_ready}, {31'd0, k % 3 == 0});
            @(negedge clk);
        end
        bus.req_valid = 0;
        drain();

        // reset during WAIT drops an uncommitted store
        issue(1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 32'h0, 0);
        send(1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wait_ready", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mid_reset_ready", {31'd0, bus.req_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("post_reset_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        repeat (3) @(negedge clk);
        issue(0, 2'b10, 0, 32'h20, 32'h0, 32'hCAFE_F00D, 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
